data_mem_responder: RTL
=======================

# data_mem_responder

Data-memory responder for the 9-bit accumulator-style core. It serves the load (LDR) and store (STR) requests the control decoder issues, replacing the combinational `mem_read_value` path with a registered valid/ready request and response interface. It owns the 256×8 data store and has a hardware clear engine, so benches and the top level can zero memory without 256 store instructions.

## Interface
- `AW`, default 8: address width.
- `DW`, default 8: data width.
- `DEPTH`, default `2**AW`: number of entries.

- `Clk`, input, 1: the single clock. All state changes on its rising edge.
- `Reset_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: the block can accept a request this cycle.
- `req_write`, input, 1: 1 means store, 0 means load.
- `req_addr`, input, AW: the address, taken from the register value.
- `req_wdata`, input, DW: the store data.
- `resp_valid`, output, 1: a one-cycle completion pulse.
- `resp_rdata`, output, DW: the load data, or the echoed store data.
- `clear_start`, input, 1: a request to zero the entire memory.
- `clear_busy`, output, 1: a clear sweep is in progress.
- `clear_done`, output, 1: a one-cycle pulse when the sweep finishes.

## Operation
- **States:**
  - `DM_IDLE`: serves requests; `req_ready` is 1.
  - `DM_CLEAR`: runs the sweep; `req_ready` is 0.
- **Reset values:** state is `DM_IDLE`, `req_ready` is 1, `resp_valid` is 0, `resp_rdata` is 0, `clear_busy` is 0, `clear_done` is 0, and the sweep counter is 0. Array contents are not reset and are undefined.
- **Handshake:** a request is accepted on an edge where `req_valid && req_ready`. There is no response backpressure, because the consumer always takes the response.
- **Load:** `resp_rdata` becomes `mem[req_addr]`, sampled at the accept edge, and `resp_valid` is 1 for exactly one cycle.
- **Store:** `mem[req_addr]` becomes `req_wdata` at the accept edge. `resp_rdata` becomes `req_wdata` and `resp_valid` pulses, which acts as the store acknowledge.
- `resp_rdata` holds its last value while `resp_valid` is 0.
- **Back-to-back requests:** one request per cycle, sustained. A load in the cycle after a store to the same address returns the new data.
- **Clear:** `clear_start` sampled in `DM_IDLE` moves the block to `DM_CLEAR`.
  - The sweep counter runs 0 to `DEPTH-1` and writes 0 to one entry per cycle.
  - After the last write the block returns to `DM_IDLE`.
- **Simultaneous `clear_start` and an accepted request in `DM_IDLE`:**
  - The request is accepted and completes normally, so a load returns the pre-clear value.
  - The clear starts at the same edge.
  - A store made by that request is overwritten by the sweep.
- `clear_start` while in `DM_CLEAR` is ignored, and the sweep is not restarted.
- `req_valid` while in `DM_CLEAR` is not accepted. The requester holds the request until `req_ready` returns.
- **Reset mid-sweep:** the block returns immediately to `DM_IDLE` with the counter at 0. Entries not yet swept keep their old values, and entries already swept read as 0.
- **Address width:** `req_addr` is exactly AW bits, so there is no out-of-range access. The sweep counter is AW+1 bits, and termination is detected on `count == DEPTH-1`.

## Timing
- Load latency is 1 cycle: accept at edge N, then `resp_valid` and `resp_rdata` are valid in cycle N to N+1.
- Store latency is 1 cycle, measured to the acknowledge. The data is visible to a load accepted at edge N+1.
- `req_ready` is a registered function of state only; it has no combinational path from `req_valid`.
- Clear sampled at edge T:
  - `clear_busy` is 1 for exactly DEPTH cycles (256 by default), covering edges T+1 through T+DEPTH, which write addresses 0 through DEPTH-1.
  - `clear_done` is 1 for the single cycle after the last write.
  - `req_ready` returns to 1 in that same cycle.
- `clear_busy` and `req_ready` are never both 1.

## Structure
- Add to the shared `definitions` package:
  - constants `DMEM_AW` = 8 and `DMEM_DW` = 8;
  - `typedef enum logic {DM_IDLE, DM_CLEAR} dmem_state_t`.
- Use one sub-module, `dmem_array`: DEPTH×DW storage with a single write port (synchronous write, asynchronous read).
  - The top level muxes the write port between the request (in `DM_IDLE`) and the sweep (in `DM_CLEAR`).
  - The top level registers the read data.
- The FSM, sweep counter, and response registers live in `data_mem_responder`.

## Test plan
- **Reset:** assert `Reset_n`=0 mid-cycle. Required: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `clear_busy`=0 immediately, without waiting for a clock edge.
- **Store then load:** store 0xA5 to 0x10, then a load from 0x10 on the next cycle. Required: an ack pulse with `resp_rdata`=0xA5, then a load response of 0xA5 one cycle after its accept.
- **Streaming:** 8 back-to-back stores (addr i, data i+0x40), then 8 loads. Required: 8 consecutive `resp_valid` pulses each way, with load i returning i+0x40.
- **Clear:** fill 0x00–0xFF, then assert `clear_start`. Required: `clear_busy` high for 256 cycles, `clear_done` for 1 cycle, `req_ready`=0 throughout, and every load afterwards returns 0x00.
- **Collision:** a load from 0x20 (holding 0x77) together with `clear_start`. Required: the response is 0x77 and the sweep proceeds. A `clear_start` pulse during the sweep must not extend `clear_busy` beyond 256 cycles.
- **Reset mid-clear:** assert reset after 100 sweep cycles, then release it. Required: `DM_IDLE` with `req_ready`=1. A load from 0x05 returns 0, and a load from 0xF0 returns its pre-clear value.

Source files
------------

// File: rtl/definitions.sv
// Shared definitions for the 9-bit accumulator core: data-memory widths and
// the responder state encoding.
package definitions;

   localparam int unsigned DMEM_AW = 8;
   localparam int unsigned DMEM_DW = 8;

   typedef enum logic {
      DM_IDLE,
      DM_CLEAR
   } dmem_state_t;

endpackage : definitions

// File: rtl/dmem_array.sv
// DEPTH x DW data store: one synchronous write port, one asynchronous read port.
module dmem_array #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 2**AW
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   // Contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : dmem_array

// File: rtl/data_mem_responder.sv
// Registered valid/ready load/store responder for the core's data memory,
// with a one-entry-per-cycle hardware clear sweep.
module data_mem_responder
   import definitions::*;
#(
   parameter int unsigned AW    = DMEM_AW,
   parameter int unsigned DW    = DMEM_DW,
   parameter int unsigned DEPTH = 2**AW
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          resp_valid,
   output logic [DW-1:0] resp_rdata,
   input  logic          clear_start,
   output logic          clear_busy,
   output logic          clear_done
);

   localparam int unsigned    CW       = AW + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEPTH - 1);

   dmem_state_t   state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          req_ready_q, req_ready_d;
   logic          resp_valid_q, resp_valid_d;
   logic [DW-1:0] resp_rdata_q, resp_rdata_d;
   logic          clear_busy_q, clear_busy_d;
   logic          clear_done_q, clear_done_d;

   logic          arr_we;
   logic [AW-1:0] arr_waddr;
   logic [DW-1:0] arr_wdata;
   logic [DW-1:0] arr_rdata;

   dmem_array #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i   (Clk),
      .we_i    (arr_we),
      .waddr_i (arr_waddr),
      .wdata_i (arr_wdata),
      .raddr_i (req_addr),
      .rdata_o (arr_rdata)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= DM_IDLE;
         count_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         clear_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         clear_busy_q <= clear_busy_d;
         clear_done_q <= clear_done_d;
      end
   end

   // Write port belongs to the request in IDLE and to the sweep in CLEAR.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      clear_busy_d = clear_busy_q;
      clear_done_d = 1'b0;
      arr_we       = 1'b0;
      arr_waddr    = req_addr;
      arr_wdata    = req_wdata;

      case (state_q)
         DM_IDLE: begin
            if (req_valid && req_ready_q) begin
               resp_valid_d = 1'b1;
               if (req_write) begin
                  arr_we       = 1'b1;
                  resp_rdata_d = req_wdata;
               end else begin
                  resp_rdata_d = arr_rdata;
               end
            end
            // A request accepted alongside the clear still completes.
            if (clear_start) begin
               state_d      = DM_CLEAR;
               count_d      = '0;
               req_ready_d  = 1'b0;
               clear_busy_d = 1'b1;
            end
         end
         DM_CLEAR: begin
            arr_we    = 1'b1;
            arr_waddr = count_q[AW-1:0];
            arr_wdata = '0;
            if (count_q == CNT_LAST) begin
               state_d      = DM_IDLE;
               count_d      = '0;
               req_ready_d  = 1'b1;
               clear_busy_d = 1'b0;
               clear_done_d = 1'b1;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         default: begin
            state_d = DM_IDLE;
         end
      endcase
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign clear_busy = clear_busy_q;
   assign clear_done = clear_done_q;

endmodule : data_mem_responder
